// File: rtl/freq_meter_pkg.sv
// ----------------------------------------------------------------------------
// freq_meter_pkg
// Shared types and helpers for the auto-ranging frequency meter.
//   meter_state_t : measurement sequencer states
//   bcd_digit_t   : one packed BCD digit
//   gate_cycles() : gate length in clock cycles for a given range
//   range_width() : width of a range index (never less than 1 bit)
// ----------------------------------------------------------------------------
package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GATE  = 2'd1,
      LATCH = 2'd2,
      CLEAR = 2'd3
   } meter_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_NINE = 4'd9;

   // Range r gates for clk_hz / 10^r cycles. The loop runs a fixed number of
   // times so the function stays a plain constant function; a gate of zero
   // cycles is meaningless, so it is floored at one.
   function automatic int unsigned gate_cycles(input int unsigned clk_hz,
                                               input int unsigned r);
      int unsigned g;
      g = clk_hz;
      for (int i = 0; i < 10; i++) begin
         if (i < int'(r)) begin
            g = g / 10;
         end
      end
      return (g == 0) ? 1 : g;
   endfunction

   function automatic int unsigned range_width(input int unsigned n_ranges);
      return (n_ranges > 1) ? $clog2(n_ranges) : 1;
   endfunction

endpackage

// File: rtl/auto_range_freq_meter_if.sv
// ----------------------------------------------------------------------------
// auto_range_freq_meter_if
// Control and result bus of the frequency meter.
//   auto_en    : 1 = auto-ranging, 0 = manual range from sel_range
//   sel_range  : manual range index
//   bcd_out    : latched BCD result, digit 0 in bits [3:0]
//   over       : latched overflow flag
//   range_idx  : range used for the latched result
//   meas_valid : one-cycle pulse when the result fields update
// master = the meter, slave = the consumer that drives the controls.
// ----------------------------------------------------------------------------
interface auto_range_freq_meter_if #(
   parameter int N_DIGITS = 8,
   parameter int N_RANGES = 3
);
   import freq_meter_pkg::*;

   localparam int RANGE_W = range_width(N_RANGES);

   logic                  auto_en;
   logic [RANGE_W-1:0]    sel_range;
   logic [4*N_DIGITS-1:0] bcd_out;
   logic                  over;
   logic [RANGE_W-1:0]    range_idx;
   logic                  meas_valid;

   modport master (
      input  auto_en, sel_range,
      output bcd_out, over, range_idx, meas_valid
   );

   modport slave (
      output auto_en, sel_range,
      input  bcd_out, over, range_idx, meas_valid
   );

endinterface

// File: rtl/bcd_digit_cnt.sv
// ----------------------------------------------------------------------------
// bcd_digit_cnt
// One decade of the cascaded BCD event counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear to 0
//   inc        : increment request (carry in from the lower decade)
//   hold       : freeze the digit (whole counter is saturated)
//   digit      : current digit value 0..9
//   carry      : carry out, combinational, so a carry ripples through all
//                decades within the same cycle
// ----------------------------------------------------------------------------
module bcd_digit_cnt
   import freq_meter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       inc,
   input  logic       hold,
   output bcd_digit_t digit,
   output logic       carry
);

   // Carry does not look at hold: the top carry is what tells the parent that
   // the counter is about to wrap, and the parent answers with hold.
   assign carry = inc && (digit == BCD_NINE);

   // Digit register: clear wins, otherwise count 0..9 and wrap unless held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit <= '0;
      end else if (clear) begin
         digit <= '0;
      end else if (inc && !hold) begin
         digit <= (digit == BCD_NINE) ? 4'd0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/auto_range_freq_meter.sv
// ----------------------------------------------------------------------------
// auto_range_freq_meter
// Counts rising edges of an asynchronous signal during a gate of
// CLK_HZ/10^r cycles and reports the count in BCD, stepping the range up on
// overflow and down when the top digit is unused (auto mode).
//   clk_50M    : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   ext_signal : measured signal, asynchronous to clk_50M
//   bus        : control inputs and latched results (master side)
// Sequence: IDLE -> CLEAR -> GATE (gate cycles) -> LATCH -> CLEAR -> ...
// The result registers load in LATCH, so they and meas_valid become visible
// during the following CLEAR cycle.
// ----------------------------------------------------------------------------
module auto_range_freq_meter
   import freq_meter_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int N_DIGITS = 8,
   parameter int N_RANGES = 3
) (
   input  logic                     clk_50M,
   input  logic                     rst_n,
   input  logic                     ext_signal,
   auto_range_freq_meter_if.master  bus
);

   localparam int RANGE_W = range_width(N_RANGES);
   localparam int GATE_W  = $clog2(CLK_HZ + 1);
   localparam logic [RANGE_W-1:0] MAX_RANGE = RANGE_W'(N_RANGES - 1);

   meter_state_t          state;
   logic [GATE_W-1:0]     gate_cnt;
   logic [RANGE_W-1:0]    cur_range;
   logic [RANGE_W-1:0]    next_range;
   logic [RANGE_W-1:0]    sel_prev;
   logic                  overflow;
   logic                  manual_mode;
   logic                  abort_gate;

   logic                  sync_1;
   logic                  sync_2;
   logic                  sync_3;
   logic                  edge_det;
   logic                  count_edge;

   bcd_digit_t            digits [N_DIGITS];
   logic [N_DIGITS:0]     carry_chain;
   logic [4*N_DIGITS-1:0] count_flat;
   logic [GATE_W-1:0]     gate_load [N_RANGES];

   // Gate reload values (gate length minus one, the counter runs down to 0).
   for (genvar g = 0; g < N_RANGES; g++) begin : g_gate
      assign gate_load[g] = GATE_W'(gate_cycles(CLK_HZ, g) - 1);
   end

   // Two flops bring ext_signal into the clock domain; the third flop holds
   // the previous synchronised level so the rising-edge pulse is registered.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         sync_3   <= 1'b0;
         edge_det <= 1'b0;
      end else begin
         sync_1   <= ext_signal;
         sync_2   <= sync_1;
         sync_3   <= sync_2;
         edge_det <= sync_2 & ~sync_3;
      end
   end

   // Edges outside GATE are simply lost rather than queued.
   assign count_edge     = edge_det && (state == GATE);
   assign carry_chain[0] = count_edge;

   // Cascaded decades. A carry out of the top decade means the counter is at
   // all nines and would wrap, so every decade is held instead.
   for (genvar d = 0; d < N_DIGITS; d++) begin : g_digit
      bcd_digit_cnt u_digit (
         .clk   (clk_50M),
         .rst_n (rst_n),
         .clear (state == CLEAR),
         .inc   (carry_chain[d]),
         .hold  (carry_chain[N_DIGITS]),
         .digit (digits[d]),
         .carry (carry_chain[d+1])
      );
      assign count_flat[4*d +: 4] = digits[d];
   end

   // Range for the next gate, consumed only in CLEAR. Overflow and the top
   // digit still describe the measurement just latched at that point.
   always_comb begin
      next_range = cur_range;
      if (!bus.auto_en) begin
         next_range = (bus.sel_range > MAX_RANGE) ? MAX_RANGE : bus.sel_range;
      end else if (overflow && (cur_range < MAX_RANGE)) begin
         next_range = cur_range + 1'b1;
      end else if (!overflow && (digits[N_DIGITS-1] == 4'd0) &&
                   (cur_range != '0)) begin
         next_range = cur_range - 1'b1;
      end
   end

   // A manual range change mid-gate makes the running count meaningless.
   // The mode is the one captured at the start of the gate, so toggling
   // auto_en alone never aborts.
   assign abort_gate = (state == GATE) && manual_mode &&
                       (bus.sel_range != sel_prev);

   // Sequencer with registered results. meas_valid defaults low every cycle
   // so it can only pulse for the single cycle after LATCH.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         gate_cnt       <= '0;
         cur_range      <= '0;
         sel_prev       <= '0;
         overflow       <= 1'b0;
         manual_mode    <= 1'b0;
         bus.bcd_out    <= '0;
         bus.over       <= 1'b0;
         bus.range_idx  <= '0;
         bus.meas_valid <= 1'b0;
      end else begin
         sel_prev       <= bus.sel_range;
         bus.meas_valid <= 1'b0;
         if (carry_chain[N_DIGITS]) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               state <= CLEAR;
            end
            CLEAR: begin
               overflow    <= 1'b0;
               cur_range   <= next_range;
               manual_mode <= !bus.auto_en;
               gate_cnt    <= gate_load[next_range];
               state       <= GATE;
            end
            GATE: begin
               if (abort_gate) begin
                  state <= CLEAR;
               end else if (gate_cnt == '0) begin
                  state <= LATCH;
               end else begin
                  gate_cnt <= gate_cnt - 1'b1;
               end
            end
            LATCH: begin
               bus.bcd_out    <= count_flat;
               bus.over       <= overflow;
               bus.range_idx  <= cur_range;
               bus.meas_valid <= 1'b1;
               state          <= CLEAR;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_auto_range_freq_meter.sv
// ----------------------------------------------------------------------------
// tb_auto_range_freq_meter
// Directed bench for the frequency meter at CLK_HZ=1000, N_DIGITS=2,
// N_RANGES=3 (gates of 1000/100/10 cycles). Each expected result is queued
// when its stimulus is applied and compared when meas_valid pulses, including
// the distance in cycles from the previous reference point.
// ----------------------------------------------------------------------------
module tb_auto_range_freq_meter;

   localparam int CLK_HZ   = 1000;
   localparam int N_DIGITS = 2;
   localparam int N_RANGES = 3;

   logic clk_50M    = 1'b0;
   logic rst_n      = 1'b0;
   logic ext_signal = 1'b0;

   auto_range_freq_meter_if #(.N_DIGITS(N_DIGITS), .N_RANGES(N_RANGES)) mif ();

   auto_range_freq_meter #(
      .CLK_HZ   (CLK_HZ),
      .N_DIGITS (N_DIGITS),
      .N_RANGES (N_RANGES)
   ) dut (
      .clk_50M    (clk_50M),
      .rst_n      (rst_n),
      .ext_signal (ext_signal),
      .bus        (mif.master)
   );

   typedef struct {
      int         lo;
      int         hi;
      logic       over;
      logic [1:0] rng;
      int         gap;
   } exp_t;

   exp_t sb[$];
   int   checks     = 0;
   int   failures   = 0;
   int   cyc        = 0;
   int   ref_cyc    = 0;
   int   ext_period = 40;
   int   ext_phase  = 0;
   logic ext_level  = 1'b0;

   always #5 clk_50M = ~clk_50M;

   // Posedge counter; sampled on negedges so it reads as "edges so far".
   always @(posedge clk_50M) cyc++;

   // Square wave of ext_period cycles (50% duty), or a constant level when
   // ext_period is 0. Changes land on negedges, away from the sampling edge.
   initial begin
      forever begin
         @(negedge clk_50M);
         if (ext_period == 0) begin
            ext_signal = ext_level;
         end else begin
            ext_signal = (ext_phase < ext_period / 2);
            ext_phase  = (ext_phase + 1 >= ext_period) ? 0 : ext_phase + 1;
         end
      end
   end

   // Hard time limit in case the flow itself stalls.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int bcd2bin(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_win(input string tag, input int obs, input int lo,
                            input int hi);
      checks++;
      assert ((obs >= lo) && (obs <= hi)) else begin
         failures++;
         $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic push_exp(input int lo, input int hi, input logic over,
                           input logic [1:0] rng, input int gap);
      exp_t e;
      e.lo   = lo;
      e.hi   = hi;
      e.over = over;
      e.rng  = rng;
      e.gap  = gap;
      sb.push_back(e);
   endtask

   // Inputs change immediately; callers invoke this on a negedge.
   task automatic apply_stimulus(input int period, input logic level,
                                 input logic auto_mode, input logic [1:0] sel);
      if (period != ext_period) begin
         ext_phase = 0;
      end
      ext_period    = period;
      ext_level     = level;
      mif.auto_en   = auto_mode;
      mif.sel_range = sel;
   endtask

   // Wait (bounded) for the next meas_valid and compare it against the
   // oldest queued expectation.
   task automatic check_output(input string tag);
      exp_t e;
      int   waited;
      bit   seen;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("[TB] FAIL %s: observed empty scoreboard expected an entry", tag);
         return;
      end
      e      = sb.pop_front();
      waited = 0;
      seen   = 1'b0;
      while (!seen && (waited < e.gap + 50)) begin
         @(negedge clk_50M);
         waited++;
         if (mif.meas_valid === 1'b1) begin
            seen = 1'b1;
         end
      end
      check_eq({tag, "_valid_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check_eq({tag, "_gap"}, 32'(cyc - ref_cyc), 32'(e.gap));
         check_win({tag, "_count"}, bcd2bin(mif.bcd_out), e.lo, e.hi);
         check_eq({tag, "_over"}, 32'(mif.over), 32'(e.over));
         check_eq({tag, "_range"}, 32'(mif.range_idx), 32'(e.rng));
      end
      ref_cyc = cyc;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_bcd"}, 32'(mif.bcd_out), 32'd0);
      check_eq({tag, "_over"}, 32'(mif.over), 32'd0);
      check_eq({tag, "_range"}, 32'(mif.range_idx), 32'd0);
      check_eq({tag, "_valid"}, 32'(mif.meas_valid), 32'd0);
   endtask

   initial begin
      // Reset state, manual range 0, 40-cycle input period.
      apply_stimulus(40, 1'b0, 1'b0, 2'd0);
      rst_n = 1'b0;
      repeat (5) @(negedge clk_50M);
      check_outputs_zero("reset");
      rst_n   = 1'b1;
      ref_cyc = cyc;

      // Manual range 0: 25 edges per 1000-cycle gate, one result every 1002.
      push_exp(24, 26, 1'b0, 2'd0, 1003);
      push_exp(24, 26, 1'b0, 2'd0, 1002);
      push_exp(24, 26, 1'b0, 2'd0, 1002);
      check_output("man_r0_first");
      check_output("man_r0_second");
      check_output("man_r0_third");

      // Reset in gate cycle 300: outputs drop at once, restart from scratch.
      repeat (300) @(negedge clk_50M);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("midgate_reset");
      repeat (3) @(negedge clk_50M);
      rst_n   = 1'b1;
      ref_cyc = cyc;
      push_exp(24, 26, 1'b0, 2'd0, 1003);
      check_output("after_reset");

      // sel_range 0->2 at gate cycle 500 aborts; abort CLEAR + 10 + LATCH.
      repeat (500) @(negedge clk_50M);
      apply_stimulus(40, 1'b0, 1'b0, 2'd2);
      ref_cyc = cyc;
      push_exp(0, 1, 1'b0, 2'd2, 13);
      check_output("abort_r2");

      // Out-of-range manual index set during CLEAR clamps to range 2.
      apply_stimulus(40, 1'b0, 1'b0, 2'd3);
      push_exp(0, 1, 1'b0, 2'd2, 12);
      check_output("clamp_r2");

      // Auto from reset with an 8-cycle period: overflow, then range 1.
      rst_n = 1'b0;
      apply_stimulus(8, 1'b0, 1'b1, 2'd3);
      repeat (3) @(negedge clk_50M);
      rst_n   = 1'b1;
      ref_cyc = cyc;
      push_exp(99, 99, 1'b1, 2'd0, 1003);
      push_exp(12, 13, 1'b0, 2'd1, 102);
      push_exp(12, 13, 1'b0, 2'd1, 102);
      check_output("auto_ovf_r0");
      check_output("auto_up_r1");
      check_output("auto_stay_r1");

      // Slow input while at range 1: top digit empty, so step down to 0.
      apply_stimulus(200, 1'b0, 1'b1, 2'd3);
      push_exp(0, 2, 1'b0, 2'd1, 102);
      push_exp(4, 6, 1'b0, 2'd0, 1002);
      check_output("slow_r1");
      check_output("slow_down_r0");

      // Input held high: park at range 2 manually, then auto walks down.
      apply_stimulus(0, 1'b1, 1'b0, 2'd3);
      push_exp(0, 1, 1'b0, 2'd2, 12);
      check_output("hi_man_r2");
      apply_stimulus(0, 1'b1, 1'b1, 2'd3);
      push_exp(0, 0, 1'b0, 2'd1, 102);
      push_exp(0, 0, 1'b0, 2'd0, 1002);
      push_exp(0, 0, 1'b0, 2'd0, 1002);
      check_output("hi_walk_r1");
      check_output("hi_walk_r0");
      check_output("hi_stay_r0");

      // Input held low: same walk-down with no edges at all.
      apply_stimulus(0, 1'b0, 1'b0, 2'd3);
      push_exp(0, 0, 1'b0, 2'd2, 12);
      check_output("lo_man_r2");
      apply_stimulus(0, 1'b0, 1'b1, 2'd3);
      push_exp(0, 0, 1'b0, 2'd1, 102);
      push_exp(0, 0, 1'b0, 2'd0, 1002);
      push_exp(0, 0, 1'b0, 2'd0, 1002);
      check_output("lo_walk_r1");
      check_output("lo_walk_r0");
      check_output("lo_stay_r0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/auto_range_freq_meter.md
AUTO_RANGE_FREQ_METER -- requirements
Module: auto_range_freq_meter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000: system clock frequency in Hz.
REQ-002 SHALL have parameter N_DIGITS, default 8: number of BCD result digits, 2..10.
REQ-003 SHALL have parameter N_RANGES, default 3: number of gate ranges; range r gate = CLK_HZ/10^r cycles.
REQ-004 Port clk_50M  input  1: single clock, all logic rising-edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port ext_signal  input  1: measured signal, asynchronous to clk_50M.
REQ-007 Port auto_en  input  1: 1 = auto-ranging, 0 = manual range from sel_range.
REQ-008 Port sel_range  input  $clog2(N_RANGES) (min 1): manual range index, clamped to N_RANGES-1.
REQ-009 Port bcd_out  output  4*N_DIGITS: latched result, digit 0 in bits [3:0] (least significant).
REQ-010 Port over  output  1: latched overflow flag for bcd_out.
REQ-011 Port range_idx  output  $clog2(N_RANGES) (min 1): range used for the latched result (decimal-point position).
REQ-012 Port meas_valid  output  1: one-cycle pulse when bcd_out/over/range_idx update.

Function
REQ-013 ext_signal SHALL pass a 2-FF synchroniser, then a registered rising-edge detector; an edge is counted only if its detect pulse occurs while state = GATE.
REQ-014 FSM states: IDLE, GATE, LATCH, CLEAR; IDLE->CLEAR on first cycle after reset release; CLEAR->GATE; GATE->LATCH after exactly gate cycles of current range; LATCH->CLEAR.
REQ-015 GATE SHALL last exactly CLK_HZ/10^r cycles; LATCH and CLEAR 1 cycle each; measurement period = gate+2 cycles.
REQ-016 Counter: N_DIGITS cascaded BCD digits, each 0..9, carry ripples within the same cycle.
REQ-017 Increment when counter = all 9s SHALL hold all 9s and set internal overflow flag (saturating, sticky until CLEAR).
REQ-018 In LATCH: bcd_out, over, range_idx take counter, overflow flag and current range; meas_valid = 1 that cycle only.
REQ-019 In CLEAR: counter and overflow flag cleared; range for next gate selected.
REQ-020 Auto range selection in CLEAR: overflow and range < N_RANGES-1 -> range+1; no overflow, most significant digit 0, range > 0 -> range-1; otherwise unchanged.
REQ-021 Manual mode in CLEAR: range = min(sel_range, N_RANGES-1).
REQ-022 Change of sel_range while auto_en = 0 and state = GATE SHALL abort the gate: go to CLEAR next cycle, no LATCH, no meas_valid.
REQ-023 auto_en change SHALL take effect at the next CLEAR only; never aborts a gate.
REQ-024 Edges arriving in LATCH or CLEAR SHALL be dropped, not deferred.
REQ-025 Outputs hold their last latched values between meas_valid pulses.

Reset
REQ-026 rst_n = 0 SHALL asynchronously force: state IDLE, counter 0, overflow 0, current range 0, synchroniser and edge-detect regs 0.
REQ-027 Reset values: bcd_out = 0, over = 0, range_idx = 0, meas_valid = 0.
REQ-028 Reset asserted mid-gate SHALL discard the measurement; no meas_valid until a full gate completes after release.

Structure
REQ-029 Shared package freq_meter_pkg SHALL hold the FSM state enum, the BCD digit typedef (4-bit) and a constant function returning gate cycles for range r.
REQ-030 One sub-module bcd_digit_cnt (single digit: clear, inc in, carry out, saturate hold) SHALL be instantiated N_DIGITS times.

Verification (bench parameters CLK_HZ=1000, N_DIGITS=2, N_RANGES=3; gates 1000/100/10 cycles)
REQ-031 Manual range 0, ext_signal period 40 cycles -> each meas_valid: bcd_out = 0x25 (+/-1 LSB), over = 0, range_idx = 0, meas_valid every 1002 cycles.
REQ-032 Auto, ext period 8 cycles, from reset -> first result over = 1, bcd_out = 0x99, range_idx = 0; second result range_idx = 1, bcd_out = 0x12 or 0x13, over = 0; stays range 1.
REQ-033 Auto, settled at range 1, ext period changed to 200 cycles -> result with digit 1 = 0, range_idx = 1; next result range_idx = 0, bcd_out = 0x05 (+/-1).
REQ-034 Manual, sel_range 0->2 at cycle 500 of a gate -> no meas_valid for that gate; next meas_valid 12 cycles after abort CLEAR, range_idx = 2.
REQ-035 rst_n pulsed low at cycle 300 of a gate -> all outputs 0 immediately; first meas_valid 1003 cycles after release (range 0).
REQ-036 ext_signal held at 1 (and separately at 0) -> bcd_out = 0x00, over = 0 every result; auto range walks down to and stays at 0.
